// File: rtl/wb_regfile.sv
// wb_regfile: MEM/WB write-back decode, 32x32 register file and retire counter.
// Optional macro WB_BYPASS_EN: write-through from wb_data to the read ports.
module wb_regfile #(
    parameter int DW   = 32,
    parameter int NREG = 32,
    parameter int CNTW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [DW-1:0]   MEMOutin,
    input  logic [DW-1:0]   ALUOutin,
    input  logic [31:0]     IRin,
    input  logic [4:0]      raddr1,
    input  logic [4:0]      raddr2,
    output logic [DW-1:0]   rdata1,
    output logic [DW-1:0]   rdata2,
    output logic            wb_we,
    output logic [4:0]      wb_addr,
    output logic [DW-1:0]   wb_data,
    output logic [CNTW-1:0] retire_cnt
);

    logic [5:0]      op;
    logic            dec_wr;
    logic            dec_mem;
    logic [4:0]      dec_dest;

    logic [DW-1:0]   regs_q [NREG];
    logic [DW-1:0]   regs_d [NREG];
    logic [CNTW-1:0] cnt_q;
    logic [CNTW-1:0] cnt_d;

    assign op = IRin[31:26];

    always_comb begin
        dec_wr   = 1'b0;
        dec_mem  = 1'b0;
        dec_dest = IRin[20:16];
        unique case (1'b1)
            (op == 6'h00): begin
                dec_wr   = (IRin[5:0] != 6'h08);
                dec_dest = IRin[15:11];
            end
            (op == 6'h23): begin
                dec_wr  = 1'b1;
                dec_mem = 1'b1;
            end
            (op[5:3] == 3'b001): begin
                dec_wr = 1'b1;
            end
            (op == 6'h03): begin
                dec_wr   = 1'b1;
                dec_dest = 5'd31;
            end
            default: begin
            end
        endcase
    end

    // Register 0 is never written, so it needs no special storage.
    always_comb begin
        wb_we   = 1'b0;
        wb_addr = '0;
        wb_data = '0;
        if (rst_n) begin
            wb_we   = dec_wr && (dec_dest != 5'd0);
            wb_addr = dec_dest;
            wb_data = dec_mem ? MEMOutin : ALUOutin;
        end
    end

    always_comb begin
        regs_d = regs_q;
        if (wb_we) begin
            regs_d[wb_addr] = wb_data;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (IRin != 32'h0) begin
            cnt_d = cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            cnt_q <= '0;
        end else begin
            regs_q <= regs_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        rdata1 = '0;
        if (rst_n && raddr1 != 5'd0) begin
            rdata1 = regs_q[raddr1];
        end
`ifdef WB_BYPASS_EN
        if (wb_we && raddr1 == wb_addr) begin
            rdata1 = wb_data;
        end
`endif
    end

    always_comb begin
        rdata2 = '0;
        if (rst_n && raddr2 != 5'd0) begin
            rdata2 = regs_q[raddr2];
        end
`ifdef WB_BYPASS_EN
        if (wb_we && raddr2 == wb_addr) begin
            rdata2 = wb_data;
        end
`endif
    end

    assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: scoreboard bench for wb_regfile against a register-array model.
// Counter is built 4 bits wide so wrap-around occurs during the run.
module tb_wb_regfile;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [31:0]   MEMOutin = '0;
    logic [31:0]   ALUOutin = '0;
    logic [31:0]   IRin = '0;
    logic [4:0]    raddr1 = '0;
    logic [4:0]    raddr2 = '0;
    logic [31:0]   rdata1;
    logic [31:0]   rdata2;
    logic          wb_we;
    logic [4:0]    wb_addr;
    logic [31:0]   wb_data;
    logic [CW-1:0] retire_cnt;

    always #5 clk = ~clk;

    wb_regfile #(.DW(32), .NREG(32), .CNTW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .MEMOutin(MEMOutin), .ALUOutin(ALUOutin), .IRin(IRin),
        .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rdata1), .rdata2(rdata2),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .retire_cnt(retire_cnt)
    );

    typedef struct {
        int          step;
        logic        we;
        bit          chk_ad;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sbq[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          stepno = 0;
    logic [31:0] mregs [32];
    int          mcnt = 0;

    task automatic check(string name, int step, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
    endtask

    // Architectural rule: which instructions write, where, and from which source.
    task automatic model_decode(input logic [31:0] ir, output bit wr,
                                output logic [4:0] d, output bit mem, output bit known);
        int op;
        op = int'(ir[31:26]);
        wr = 0; mem = 0; known = 1; d = ir[20:16];
        if (op == 0) begin
            wr = (ir[5:0] != 6'h08);
            d  = ir[15:11];
        end else if (op == 'h23) begin
            wr = 1; mem = 1;
        end else if (op >= 'h08 && op <= 'h0F) begin
            wr = 1;
        end else if (op == 'h03) begin
            wr = 1; d = 5'd31;
        end else begin
            known = 0;
        end
    endtask

    task automatic cycle();
        exp_t e;
        bit wr, mem, known;
        logic [4:0] d;
        e.step = stepno++;
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) mregs[i] = '0;
            mcnt = 0;
            e.we = 0; e.chk_ad = 1; e.addr = '0; e.data = '0;
            e.r1 = '0; e.r2 = '0;
        end else begin
            model_decode(IRin, wr, d, mem, known);
            e.we     = wr && (d != 5'd0);
            e.chk_ad = known;
            e.addr   = d;
            e.data   = mem ? MEMOutin : ALUOutin;
            e.r1     = (raddr1 == 0) ? 32'h0 : mregs[raddr1];
            e.r2     = (raddr2 == 0) ? 32'h0 : mregs[raddr2];
`ifdef WB_BYPASS_EN
            if (e.we && raddr1 == d) e.r1 = e.data;
            if (e.we && raddr2 == d) e.r2 = e.data;
`endif
        end
        e.cnt = 32'(mcnt);
        sbq.push_back(e);
        @(posedge clk);
        if (rst_n) begin
            if (e.we) mregs[e.addr] = e.data;
            if (IRin != 32'h0) mcnt = (mcnt + 1) % (1 << CW);
        end
        #1;
    endtask

    task automatic issue(logic [31:0] ir, logic [31:0] mem, logic [31:0] alu,
                         logic [4:0] a1, logic [4:0] a2);
        IRin = ir; MEMOutin = mem; ALUOutin = alu;
        raddr1 = a1; raddr2 = a2;
        cycle();
    endtask

    function automatic logic [31:0] rand_ir();
        logic [31:0] ir;
        int k;
        ir = $urandom;
        k  = $urandom_range(0, 10);
        case (k)
            0:       begin
                         ir[31:26] = 6'h00;
                         if ($urandom_range(0, 3) == 0) ir[5:0] = 6'h08;
                     end
            1:       ir[31:26] = 6'h23;
            2, 3:    ir[31:26] = 6'(8 + $urandom_range(0, 7));
            4:       ir[31:26] = 6'h03;
            5:       ir[31:26] = 6'h2B;
            6:       ir[31:26] = 6'h04;
            7:       ir[31:26] = 6'h05;
            8:       ir[31:26] = 6'h02;
            9:       ir = '0;
            default: begin
                     end
        endcase
        return ir;
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("wb_we", e.step, 32'(wb_we), 32'(e.we));
                if (e.chk_ad) begin
                    check("wb_addr", e.step, 32'(wb_addr), 32'(e.addr));
                    check("wb_data", e.step, wb_data, e.data);
                end
                check("rdata1", e.step, rdata1, e.r1);
                check("rdata2", e.step, rdata2, e.r2);
                check("retire_cnt", e.step, 32'(retire_cnt), e.cnt);
            end
        end
    end

    initial begin : stim
        logic [31:0] ir;
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        IRin = 32'h8C0A0000; MEMOutin = 32'h0BADF00D; ALUOutin = 32'h1111;
        for (int i = 0; i < 4; i++) begin
            raddr1 = 5'($urandom); raddr2 = 5'($urandom);
            cycle();
        end
        raddr1 = 5'd10; raddr2 = 5'd10;
        cycle();
        rst_n = 1'b1;
        cycle();
        issue(32'h0, 0, 0, 10, 0);

        issue(32'h8C050000, 32'hDEADBEEF, 32'h1234, 0, 0);
        issue(32'h00003820, 32'h0, 32'h55, 5, 0);
        issue(32'h20000001, 32'h0, 32'hFFFF, 7, 0);
        issue(32'h0C000010, 32'h0, 32'h00400008, 0, 0);
        issue(32'hAC050004, 32'h77, 32'h88, 31, 5);
        issue(32'h10000003, 32'h77, 32'h88, 7, 5);
        issue(32'h03E00008, 32'h77, 32'h88, 31, 0);
        issue(32'h0, 32'h77, 32'h88, 31, 7);
        issue(32'h20090000, 32'h0, 32'h1, 9, 9);
        issue(32'h20090000, 32'h0, 32'hA5A5A5A5, 0, 9);
        issue(32'h0, 32'h0, 32'h0, 9, 9);

        for (int i = 0; i < 300; i++) begin
            ir = rand_ir();
            IRin = ir; MEMOutin = $urandom; ALUOutin = $urandom;
            raddr1 = ($urandom_range(0, 2) == 0) ? ir[20:16] : 5'($urandom);
            raddr2 = ($urandom_range(0, 2) == 0) ? ir[15:11] : 5'($urandom);
            cycle();
        end

        issue(32'h20030000, 32'h0, 32'h33, 3, 0);
        issue(32'h0, 32'h0, 32'h0, 3, 3);
        rst_n = 1'b0;
        issue(32'h0, 32'h0, 32'h0, 3, 3);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) issue(32'hAC050004, 0, 0, 3, 9);
        issue(32'h0, 32'h0, 32'h0, 3, 9);
        issue(32'h0, 32'h0, 32'h0, 0, 31);

        @(negedge clk);
        @(negedge clk);
        check("sb_drain", -1, 32'(sbq.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
